power_acc: RTL and testbench

- Frame accumulator directly downstream of the power stage; consumes its o_valid/o_data stream (64-bit results, no backpressure available upstream).
- Sums a programmable number of consecutive valid samples into a saturating accumulator.
- Presents each frame total on a valid/ready output with a one-entry result register.
- Reports dropped frames and saturation.

---
 rtl/power_pkg.sv | 17 +
 rtl/power_acc_out_reg.sv | 73 +++++++
 rtl/power_acc.sv | 151 +++++++++++++++
 tb/tb_power_acc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/power_pkg.sv
// Shared definitions for the power stage and its frame accumulator.
//   state_e          : accumulator FSM state (IDLE, ACC)
//   DATA_WIDTH       : default power stage input width
//   POWER_OUT_WIDTH  : default power stage output width (accumulator input)
//   ACC_WIDTH        : default accumulator / frame result width
package power_pkg;

   localparam int DATA_WIDTH      = 32;
   localparam int POWER_OUT_WIDTH = 64;
   localparam int ACC_WIDTH       = 72;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_e;

endpackage : power_pkg

// File: rtl/power_acc_out_reg.sv
// One-entry result register for the frame accumulator, with drop detection.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   load              : a frame completed this cycle
//   load_data/_sat    : completed frame total and its saturation flag
//   o_valid/o_ready   : result handshake towards downstream
//   o_data/o_sat      : held result
//   drop              : one-cycle pulse, a completed frame found the register
//                       full and was discarded
//
// Handshake: a transfer happens on a rising edge where o_valid && o_ready.
// While o_valid=1 and no transfer happens, o_data and o_sat do not change.
// A load on the same edge as a transfer replaces the result with no bubble;
// a load while the result is held and not transferring is discarded.
module power_acc_out_reg #(
   parameter int W = 72
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         load_sat,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [W-1:0] o_data,
   output logic         o_sat,
   output logic         drop
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         sat_q, sat_d;
   logic         drop_q, drop_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sat_d   = sat_q;
      drop_d  = 1'b0;
      if (valid_q && o_ready) begin
         valid_d = 1'b0;
      end
      if (load) begin
         if (valid_q && !o_ready) begin
            drop_d = 1'b1;
         end else begin
            valid_d = 1'b1;
            data_d  = load_data;
            sat_d   = load_sat;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sat_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sat_q   <= sat_d;
         drop_q  <= drop_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_sat   = sat_q;
   assign drop    = drop_q;

endmodule : power_acc_out_reg

// File: rtl/power_acc.sv
// Frame accumulator downstream of the power stage. Sums a programmable
// number of consecutive valid samples into a saturating accumulator and
// presents each frame total through a one-entry valid/ready result register.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_valid/i_data: sample stream from the power stage (no backpressure)
//   i_len         : samples per frame, taken on a frame's first sample;
//                   0 means 2^CNT_WIDTH
//   o_valid/o_ready/o_data/o_sat : frame result handshake
//   o_busy        : FSM is in ACC (frame in progress); this is the FSM state
//   o_drop        : one-cycle pulse, a completed frame was discarded
//   o_drop_cnt    : saturating count of discarded frames
module power_acc #(
   parameter int IN_WIDTH  = power_pkg::POWER_OUT_WIDTH,
   parameter int ACC_WIDTH = power_pkg::ACC_WIDTH,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_valid,
   input  logic [IN_WIDTH-1:0]  i_data,
   input  logic [CNT_WIDTH-1:0] i_len,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [ACC_WIDTH-1:0] o_data,
   output logic                 o_sat,
   output logic                 o_busy,
   output logic                 o_drop,
   output logic [CNT_WIDTH-1:0] o_drop_cnt
);

   import power_pkg::*;

   // Length and sample counters need one extra bit to represent 2^CNT_WIDTH.
   localparam int LW = CNT_WIDTH + 1;
   localparam logic [LW-1:0] FULL_LEN = LW'(1) << CNT_WIDTH;

   state_e               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [LW-1:0]        cnt_q, cnt_d;
   logic [LW-1:0]        len_q, len_d;
   logic                 sat_q, sat_d;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   logic                 load;
   logic [ACC_WIDTH-1:0] load_data;
   logic                 load_sat;
   logic                 drop;

   logic [ACC_WIDTH-1:0] data_ext;
   logic [ACC_WIDTH:0]   sum_w;
   logic                 carry;
   logic [ACC_WIDTH-1:0] acc_sat;
   logic [LW-1:0]        len_eff;
   logic [LW-1:0]        cnt_inc;

   assign data_ext = ACC_WIDTH'(i_data);
   assign sum_w    = {1'b0, acc_q} + {1'b0, data_ext};
   assign carry    = sum_w[ACC_WIDTH];
   // Clamp to all-ones on carry-out.
   assign acc_sat  = carry ? '1 : sum_w[ACC_WIDTH-1:0];
   assign len_eff  = (i_len == '0) ? FULL_LEN : {1'b0, i_len};
   assign cnt_inc  = cnt_q + LW'(1);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      sat_d     = sat_q;
      load      = 1'b0;
      load_data = '0;
      load_sat  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_valid) begin
               len_d = len_eff;
               acc_d = data_ext;
               cnt_d = LW'(1);
               sat_d = 1'b0;
               if (len_eff == LW'(1)) begin
                  // Single-sample frame completes immediately.
                  load      = 1'b1;
                  load_data = data_ext;
               end else begin
                  state_d = ACC;
               end
            end
         end
         ACC: begin
            if (i_valid) begin
               acc_d = acc_sat;
               cnt_d = cnt_inc;
               sat_d = sat_q | carry;
               if (cnt_inc == len_q) begin
                  load      = 1'b1;
                  load_data = acc_sat;
                  load_sat  = sat_q | carry;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         len_q      <= '0;
         sat_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         sat_q      <= sat_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   power_acc_out_reg #(
      .W (ACC_WIDTH)
   ) u_out_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .load_data (load_data),
      .load_sat  (load_sat),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_data    (o_data),
      .o_sat     (o_sat),
      .drop      (drop)
   );

   assign o_busy     = (state_q == ACC);
   assign o_drop     = drop;
   assign o_drop_cnt = drop_cnt_q;

endmodule : power_acc

// File: tb/tb_power_acc.sv
// Directed bench for power_acc, built with ACC_WIDTH = IN_WIDTH = 64 so the
// carry-out clamp is reachable. Expected frame results are queued when a
// frame is issued; a monitor pops and compares on every output transfer.
module tb_power_acc;

   localparam int W  = 64;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_valid = 1'b0;
   logic [W-1:0]  i_data = '0;
   logic [CW-1:0] i_len = '0;
   logic          o_valid;
   logic          o_ready = 1'b0;
   logic [W-1:0]  o_data;
   logic          o_sat;
   logic          o_busy;
   logic          o_drop;
   logic [CW-1:0] o_drop_cnt;

   typedef struct packed {
      logic [W-1:0] data;
      logic         sat;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   power_acc #(
      .IN_WIDTH  (W),
      .ACC_WIDTH (W),
      .CNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .i_len      (i_len),
      .o_valid    (o_valid),
      .o_ready    (o_ready),
      .o_data     (o_data),
      .o_sat      (o_sat),
      .o_busy     (o_busy),
      .o_drop     (o_drop),
      .o_drop_cnt (o_drop_cnt)
   );

   // clock
   always #5 clk = ~clk;

   // check helper
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // drivers
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic send(input logic [W-1:0] d, input logic [CW-1:0] len);
      i_valid = 1'b1;
      i_data  = d;
      i_len   = len;
      cycle();
      i_valid = 1'b0;
   endtask

   task automatic expect_frame(input logic [W-1:0] d, input logic s);
      exp_t e;
      e.data = d;
      e.sat  = s;
      exp_q.push_back(e);
   endtask

   // scoreboard monitor: a transfer happens on the next rising edge
   always @(negedge clk) begin
      if (reset_n && o_valid && o_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got data %0h sat %0b, expected none", o_data, o_sat);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result_data", o_data, e.data);
            check("result_sat", W'(o_sat), W'(e.sat));
         end
      end
   end

   initial begin
      logic [W-1:0] ones;
      ones = '1;

      // reset state
      #12;
      check("rst_valid", W'(o_valid), '0);
      check("rst_busy", W'(o_busy), '0);
      check("rst_drop", W'(o_drop), '0);
      check("rst_drop_cnt", W'(o_drop_cnt), '0);
      check("rst_data", o_data, '0);
      check("rst_sat", W'(o_sat), '0);
      reset_n = 1'b1;
      cycle();

      // basic frame: 4+9+25+49 = 87
      o_ready = 1'b1;
      expect_frame(64'd87, 1'b0);
      send(64'd4, 8'd4);
      check("basic_busy", W'(o_busy), 64'd1);
      send(64'd9, 8'd4);
      send(64'd25, 8'd4);
      check("basic_no_early_valid", W'(o_valid), '0);
      send(64'd49, 8'd4);
      check("basic_valid", W'(o_valid), 64'd1);
      check("basic_data", o_data, 64'd87);
      cycle();
      check("basic_valid_one_cycle", W'(o_valid), '0);
      idle(1);

      // gaps and length latch: len 3 taken at frame start, 10+20+30 = 60
      expect_frame(64'd60, 1'b0);
      send(64'd10, 8'd3);
      check("gap_busy0", W'(o_busy), 64'd1);
      i_len = 8'd5;
      cycle();
      check("gap_busy1", W'(o_busy), 64'd1);
      cycle();
      check("gap_busy2", W'(o_busy), 64'd1);
      send(64'd20, 8'd5);
      send(64'd30, 8'd5);
      check("gap_valid", W'(o_valid), 64'd1);
      check("gap_data", o_data, 64'd60);
      check("gap_idle", W'(o_busy), '0);
      idle(2);

      // back-pressure and drop: 7 held, 8 discarded
      o_ready = 1'b0;
      expect_frame(64'd7, 1'b0);
      send(64'd7, 8'd1);
      check("drop_held_valid", W'(o_valid), 64'd1);
      send(64'd8, 8'd1);
      check("drop_pulse", W'(o_drop), 64'd1);
      check("drop_data_kept", o_data, 64'd7);
      cycle();
      check("drop_pulse_end", W'(o_drop), '0);
      check("drop_cnt", W'(o_drop_cnt), 64'd1);
      check("drop_data_still", o_data, 64'd7);
      o_ready = 1'b1;
      cycle();
      check("drop_released", W'(o_valid), '0);
      idle(1);

      // simultaneous completion and transfer: 5 held, then 11+12 = 23
      o_ready = 1'b0;
      expect_frame(64'd5, 1'b0);
      expect_frame(64'd23, 1'b0);
      send(64'd2, 8'd2);
      send(64'd3, 8'd2);
      cycle();
      check("simul_held", o_data, 64'd5);
      send(64'd11, 8'd2);
      o_ready = 1'b1;
      send(64'd12, 8'd2);
      check("simul_no_bubble", W'(o_valid), 64'd1);
      check("simul_new_data", o_data, 64'd23);
      check("simul_no_drop", W'(o_drop_cnt), 64'd1);
      cycle();
      check("simul_done", W'(o_valid), '0);

      // saturation on the final add
      expect_frame(ones, 1'b1);
      send(ones, 8'd2);
      send(64'd5, 8'd2);
      check("sat_final_data", o_data, ones);
      check("sat_final_flag", W'(o_sat), 64'd1);
      cycle();

      // sticky saturation: all-ones + 1 clamps, + 0 keeps flag
      expect_frame(ones, 1'b1);
      send(ones, 8'd3);
      send(64'd1, 8'd3);
      send(64'd0, 8'd3);
      check("sat_sticky", W'(o_sat), 64'd1);
      cycle();

      // len 0 means 256 samples; sat flag cleared at frame start
      expect_frame(64'd256, 1'b0);
      for (int k = 0; k < 255; k++) send(64'd1, 8'd0);
      check("len0_busy", W'(o_busy), 64'd1);
      check("len0_not_done", W'(o_valid), '0);
      send(64'd1, 8'd0);
      check("len0_data", o_data, 64'd256);
      check("len0_sat", W'(o_sat), '0);
      cycle();

      // async reset mid-frame with a held result: nothing survives, no drop
      o_ready = 1'b0;
      send(64'd9, 8'd1);
      send(64'd1, 8'd4);
      send(64'd1, 8'd4);
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_busy", W'(o_busy), '0);
      check("areset_valid", W'(o_valid), '0);
      check("areset_drop_cnt", W'(o_drop_cnt), '0);
      check("areset_drop", W'(o_drop), '0);
      #10;
      reset_n = 1'b1;
      cycle();
      o_ready = 1'b1;
      expect_frame(64'd4, 1'b0);
      for (int k = 0; k < 4; k++) send(64'd1, 8'd4);
      check("after_reset_valid", W'(o_valid), 64'd1);
      check("after_reset_data", o_data, 64'd4);
      idle(3);

      check("queue_drained", W'(exp_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_power_acc
